// File: rtl/rom_load_pkg.sv
// rom_load_pkg: shared entry type, drain states and byte swap helper for rom_load_bridge
package rom_load_pkg;
  localparam int MAX_AW = 32;
  localparam int MAX_DW = 16;
  typedef struct packed {
    logic [MAX_AW-1:0] addr;
    logic [MAX_DW-1:0] data;
  } fifo_entry_t;
  typedef enum logic {IDLE, ACK} drain_state_t;
  function automatic logic [15:0] byte_swap16(input logic [15:0] d);
    return {d[7:0], d[15:8]};
  endfunction
endpackage

// File: rtl/rom_load_fifo.sv
// rom_load_fifo: DEPTH-entry synchronous FIFO of address/data pairs with occupancy count
module rom_load_fifo
  import rom_load_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  fifo_entry_t                din,
  output fifo_entry_t                dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  fifo_entry_t mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign dout = mem[rptr];
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst | flush) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      wptr <= wptr + PW'(do_push);
      rptr <= rptr + PW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  // storage carries no reset; occupancy alone defines validity
  always_ff @(posedge clk) begin
    if (do_push & ~rst & ~flush) mem[wptr] <= din;
  end
endmodule

// File: rtl/rom_load_bridge.sv
// rom_load_bridge: buffers ioctl writes and drains them over a req/ack toggle port; ROM_LOAD_CHECKSUM_EN adds a checksum output
module rom_load_bridge
  import rom_load_pkg::*;
#(
  parameter int AW = 25,
  parameter int DW = 16,
  parameter int DEPTH = 4,
  parameter int SWAP = 1
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [AW-1:0] ioctl_addr,
  input  logic [DW-1:0] ioctl_data,
  output logic          ioctl_wait,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_we_req,
  input  logic          mem_we_ack,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] word_count,
  output logic          overflow
`ifdef ROM_LOAD_CHECKSUM_EN
  , output logic [15:0] checksum
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  drain_state_t state, state_n;
  fifo_entry_t din, head;
  logic [CW-1:0] count;
  logic [DW-1:0] head_data;
  logic full, empty, push, pop, launch, start, dl_q, armed, unused_head;
  assign start = ioctl_download & ~dl_q;
  assign push = ioctl_wr & ioctl_download & ~full;
  assign din = '{addr: MAX_AW'(ioctl_addr), data: MAX_DW'(ioctl_data)};
  assign head_data = (SWAP == 1 && DW == 16) ? DW'(byte_swap16(head.data)) : DW'(head.data);
  assign unused_head = ^head;
  assign busy = (count != '0) | (state == ACK);
  assign done = armed & ~ioctl_download & ~busy;
  rom_load_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk_sys),
    .rst(reset),
    .flush(start),
    .push(push),
    .pop(pop),
    .din(din),
    .dout(head),
    .count(count),
    .full(full),
    .empty(empty)
  );
  // drain decision: launch the head from IDLE, retire it once the ack catches up
  always_comb begin
    launch = (state == IDLE) & ~empty;
    pop = (state == ACK) & (mem_we_ack == mem_we_req);
    state_n = launch ? ACK : pop ? IDLE : state;
  end
  // state register; a reset or new download abandons any outstanding write
  always_ff @(posedge clk_sys) begin
    state <= (reset | start) ? IDLE : state_n;
  end
  // handshake, status and counters
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dl_q <= 1'b0;
      armed <= 1'b0;
      mem_we_req <= mem_we_ack;
      mem_addr <= '0;
      mem_din <= '0;
      word_count <= '0;
      overflow <= 1'b0;
      ioctl_wait <= 1'b0;
`ifdef ROM_LOAD_CHECKSUM_EN
      checksum <= '0;
`endif
    end else begin
      dl_q <= ioctl_download;
      ioctl_wait <= ~start & ((count >= CW'(DEPTH - 1)) | (~ioctl_download & busy));
      if (start) begin
        armed <= 1'b1;
        mem_we_req <= mem_we_ack;
        word_count <= '0;
        overflow <= 1'b0;
`ifdef ROM_LOAD_CHECKSUM_EN
        checksum <= '0;
`endif
      end else begin
        if (done) armed <= 1'b0;
        if (ioctl_wr & ioctl_download & full) overflow <= 1'b1;
        if (launch) begin
          mem_we_req <= ~mem_we_req;
          mem_addr <= head.addr[AW-1:0];
          mem_din <= head_data;
        end
        if (pop & ~(&word_count)) word_count <= word_count + AW'(1);
`ifdef ROM_LOAD_CHECKSUM_EN
        if (pop) checksum <= checksum + 16'(mem_din);
`endif
      end
    end
  end
endmodule

// File: tb/tb_rom_load_bridge.sv
// tb_rom_load_bridge: scoreboard bench for rom_load_bridge with a toggle-handshake memory responder
module tb_rom_load_bridge;
  logic clk = 0;
  logic reset = 1;
  logic ioctl_download = 0;
  logic ioctl_wr = 0;
  logic [24:0] ioctl_addr = '0;
  logic [15:0] ioctl_data = '0;
  logic ioctl_wait, mem_we_req, mem_we_ack, busy, done, overflow;
  logic [24:0] mem_addr, word_count;
  logic [15:0] mem_din;
`ifdef ROM_LOAD_CHECKSUM_EN
  logic [15:0] checksum;
`endif
  logic resp_ack = 1;
  logic test_flip = 0;
  logic ack_hold = 0;
  int ack_delay = 1;
  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  typedef struct {
    logic [24:0] addr;
    logic [15:0] din;
  } exp_t;
  exp_t sb_q[$];
  assign mem_we_ack = resp_ack ^ test_flip;
  always #5 clk = ~clk;

  rom_load_bridge dut (
    .clk_sys(clk),
    .reset(reset),
    .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr),
    .ioctl_data(ioctl_data),
    .ioctl_wait(ioctl_wait),
    .mem_addr(mem_addr),
    .mem_din(mem_din),
    .mem_we_req(mem_we_req),
    .mem_we_ack(mem_we_ack),
    .busy(busy),
    .done(done),
    .word_count(word_count),
    .overflow(overflow)
`ifdef ROM_LOAD_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wr(input logic [24:0] a, input logic [15:0] d, input logic [15:0] ed, input bit commit);
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr = 1;
    if (commit) sb_q.push_back('{a, ed});
    @(negedge clk);
    ioctl_wr = 0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy !== 1'b0 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // memory responder: completes a write ack_delay cycles after seeing the request toggle
  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_we_req !== mem_we_ack && !ack_hold && !reset) begin
        if (cnt >= ack_delay) begin
          resp_ack = mem_we_req ^ test_flip;
          cnt = 0;
        end else cnt++;
      end else if (mem_we_req === mem_we_ack) cnt = 0;
    end
  end

  // monitor: every new request toggle must match the oldest expected write
  initial begin
    logic prev_req = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && mem_we_req !== prev_req && mem_we_req !== mem_we_ack) begin
        if (sb_q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
        else begin
          e = sb_q.pop_front();
          chk("wr_addr", {7'd0, mem_addr}, {7'd0, e.addr});
          chk("wr_din", {16'd0, mem_din}, {16'd0, e.din});
        end
      end
      prev_req = mem_we_req;
      if (done === 1'b1) done_cnt++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, n;
    logic [15:0] bd [8] = '{16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h090A, 16'h0B0C, 16'h0D0E, 16'hF00F};
    logic [15:0] be [8] = '{16'h0201, 16'h0403, 16'h0605, 16'h0807, 16'h0A09, 16'h0C0B, 16'h0E0D, 16'h0FF0};
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("rst_wait", {31'd0, ioctl_wait}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_wc", {7'd0, word_count}, 0);
    chk("rst_ovf", {31'd0, overflow}, 0);
    chk("rst_addr", {7'd0, mem_addr}, 0);
    chk("rst_din", {16'd0, mem_din}, 0);
    chk("rst_req", {31'd0, mem_we_req}, 32'd1);
    // single write with latency, wait-while-draining and done pulse
    ack_delay = 4;
    ioctl_download = 1;
    @(negedge clk);
    wr(25'h10, 16'h1234, 16'h3412, 1);
    chk("no_toggle_yet", {31'd0, mem_we_req ^ mem_we_ack}, 0);
    chk("busy_after_push", {31'd0, busy}, 1);
    @(negedge clk);
    chk("req_toggle", {31'd0, mem_we_req ^ mem_we_ack}, 1);
    chk("single_addr", {7'd0, mem_addr}, 32'h10);
    chk("single_din", {16'd0, mem_din}, 32'h3412);
    d0 = done_cnt;
    ioctl_download = 0;
    @(negedge clk);
    chk("wait_while_drain", {31'd0, ioctl_wait}, 1);
    chk("no_early_done", done_cnt - d0, 0);
    wait_idle(50);
    repeat (4) @(negedge clk);
    chk("single_wc", {7'd0, word_count}, 1);
    chk("done_once", done_cnt - d0, 1);
    chk("wait_release", {31'd0, ioctl_wait}, 0);
    // burst against slow memory with a host that honours wait
    ack_delay = 10;
    ioctl_download = 1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      n = 0;
      while (ioctl_wait && n < 400) begin
        @(negedge clk);
        n++;
      end
      chk("host_wait_timeout", {31'd0, n >= 400}, 0);
      wr(25'(2 * i), bd[i], be[i], 1);
      if (i == 2) chk("wait_after3", {31'd0, ioctl_wait}, 0);
      if (i == 3) chk("wait_after4", {31'd0, ioctl_wait}, 1);
    end
    wait_idle(1000);
    chk("burst_wc", {7'd0, word_count}, 8);
    chk("burst_ovf", {31'd0, overflow}, 0);
    ioctl_download = 0;
    repeat (3) @(negedge clk);
    // overflow: host ignores wait while memory stalls
    ack_delay = 1;
    ack_hold = 1;
    ioctl_download = 1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) wr(25'h100 + 25'(2 * i), 16'h5500 + 16'(i), 16'h0055 + 16'(i << 8), i < 4);
    chk("ovf_set", {31'd0, overflow}, 1);
    chk("ovf_wait", {31'd0, ioctl_wait}, 1);
    ack_hold = 0;
    wait_idle(200);
    chk("ovf_wc", {7'd0, word_count}, 4);
    ioctl_download = 0;
    repeat (3) @(negedge clk);
    // restart with two entries queued behind an outstanding write
    ack_hold = 1;
    ioctl_download = 1;
    @(negedge clk);
    wr(25'h200, 16'hAABB, 16'hBBAA, 1);
    wr(25'h202, 16'hCCDD, 16'hDDCC, 1);
    wr(25'h204, 16'hEEFF, 16'hFFEE, 1);
    ioctl_download = 0;
    @(negedge clk);
    ioctl_download = 1;
    @(negedge clk);
    chk("restart_pending", sb_q.size(), 2);
    sb_q.delete();
    ack_hold = 0;
    repeat (20) @(negedge clk);
    chk("restart_wc", {7'd0, word_count}, 0);
    chk("restart_busy", {31'd0, busy}, 0);
    chk("restart_req", {31'd0, mem_we_req ^ mem_we_ack}, 0);
    wr(25'h300, 16'h1357, 16'h5713, 1);
    wait_idle(50);
    chk("restart_new_wc", {7'd0, word_count}, 1);
    // reset while a write is outstanding, late ack arrives during reset
    ack_hold = 1;
    wr(25'h400, 16'h2468, 16'h6824, 1);
    repeat (2) @(negedge clk);
    chk("inack_busy", {31'd0, busy}, 1);
    reset = 1;
    repeat (2) @(negedge clk);
    test_flip = ~test_flip;
    repeat (2) @(negedge clk);
    reset = 0;
    ack_hold = 0;
    repeat (10) @(negedge clk);
    chk("rstack_wc", {7'd0, word_count}, 0);
    chk("rstack_busy", {31'd0, busy}, 0);
    chk("rstack_req", {31'd0, mem_we_req ^ mem_we_ack}, 0);
    chk("rstack_ovf", {31'd0, overflow}, 0);
`ifdef ROM_LOAD_CHECKSUM_EN
    ioctl_download = 0;
    @(negedge clk);
    ioctl_download = 1;
    @(negedge clk);
    wr(25'h0, 16'hFFFF, 16'hFFFF, 1);
    wr(25'h2, 16'h0002, 16'h0200, 1);
    wait_idle(50);
    chk("checksum", {16'd0, checksum}, 32'h01FF);
`endif
    repeat (5) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rom_load_bridge.md
Name: rom_load_bridge

Overview:
- Parametrised successor to the single-entry ioctl-to-memory write path in the emu top.
- Sits between hps_io's ioctl download interface and a toggle-handshake memory write port, such as ddram's we_req/we_ack.
- Buffers DEPTH address/data pairs in a FIFO, generates ioctl_wait from FIFO occupancy, and drains the FIFO through a req/ack toggle handshake.
- Optional byte lane swap; reports completion and word count.

Parameters:
- AW, 25: ioctl/memory byte address width.
- DW, 16: data width; must be 8 or 16.
- DEPTH, 4: FIFO entries; power of two, at least 2.
- SWAP, 1: when 1 and DW=16, mem_din = {data[7:0], data[15:8]}; otherwise data passes straight through.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ioctl_download  in  1  download in progress.
- ioctl_wr  in  1  single-cycle write strobe.
- ioctl_addr  in  AW  write byte address.
- ioctl_data  in  DW  write data.
- ioctl_wait  out  1  back-pressure to hps_io.
- mem_addr  out  AW  address of head entry.
- mem_din  out  DW  data of head entry, after optional swap.
- mem_we_req  out  1  write request toggle.
- mem_we_ack  in  1  write acknowledge toggle; the write is complete when it equals mem_we_req.
- busy  out  1  FIFO non-empty or write outstanding.
- done  out  1  one-cycle pulse when a download has fully committed.
- word_count  out  AW  entries committed since download start.
- overflow  out  1  sticky: a write arrived while the FIFO was full.

Behaviour:
- Reset values:
  - FIFO empty; state IDLE.
  - mem_we_req <= mem_we_ack.
  - ioctl_wait=0, busy=0, done=0, word_count=0, overflow=0.
  - mem_addr/mem_din=0.
- Download start (rising edge of ioctl_download, detected with a registered copy):
  - Flush FIFO; word_count<=0; overflow<=0.
  - State IDLE; mem_we_req <= mem_we_ack. Any outstanding write is abandoned.
- Push: ioctl_wr & ioctl_download & ~full writes {addr, data} at wptr.
  - ioctl_wr while full sets overflow and drops the data.
  - ioctl_wr with ioctl_download=0 is ignored.
- ioctl_wait = registered flag, set the cycle after count reaches DEPTH-1 or more. This leaves one slot of slack for a strobe already in flight.
  - Also held high while ioctl_download=0 and busy=1, so hps_io cannot restart before the FIFO drains.
- Drain FSM:
  - IDLE: if the FIFO is non-empty, latch the head into mem_addr/mem_din, toggle mem_we_req, go to ACK.
  - ACK: when mem_we_ack==mem_we_req, pop the FIFO, word_count+1, go to IDLE.
  - Minimum 2 cycles per word; back-to-back pops occur every second cycle at best.
- Latency: write strobe at cycle N gives count=1 at N+1 and the mem_we_req toggle at N+2 with mem_addr/mem_din valid.
- mem_addr/mem_din are stable from the toggle until the ack matches.
- A push and a pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH; count width is log2(DEPTH)+1.
- busy = (count!=0) | (state==ACK).
- done pulses once, the first cycle where the download edge has fallen and busy==0.
- word_count saturates at all-ones.
- Reset asserted mid-operation: the ACK state is abandoned immediately. A later ack toggle from memory must not cause a pop; mem_we_req is realigned to mem_we_ack on every reset cycle.

Optional Feature:
- ROM_LOAD_CHECKSUM_EN defined:
  - Adds output checksum [15:0], the mod-2^16 sum of committed post-swap data words (zero-extended when DW=8).
  - Updated on pop; cleared on reset and on download start.
- Undefined: port and adder absent; behaviour otherwise identical.

Decomposition:
- Package rom_load_pkg:
  - fifo_entry_t struct {addr, data} parameterised via localparams.
  - drain_state_t enum {IDLE, ACK}.
  - function byte_swap16.
- One sub-module: rom_load_fifo (DEPTH-entry synchronous FIFO with count, full, empty). The FSM and handshake stay in the top.

Test Plan:
- Single write: download rises, write addr=0x000010 data=0x1234 with SWAP=1 -> mem_we_req toggles 2 cycles later with mem_addr=0x10, mem_din=0x3412. After the ack, word_count=1. After download falls, done pulses once.
- Burst with slow memory: 8 consecutive writes, ack delayed 10 cycles each, DEPTH=4 -> ioctl_wait rises after the 3rd push. No overflow if the host obeys wait. All 8 words are committed in order, with addresses 0,2,4,…,14.
- Overflow: ignore ioctl_wait and push 6 words with ack held back -> overflow=1. Exactly DEPTH words are committed.
- Reset in ACK: reset while a write is outstanding, then ack toggles -> no pop, word_count stays 0, mem_we_req==mem_we_ack.
- Restart: a second download starts while the FIFO holds 2 entries -> FIFO flushed, word_count=0, and the stale entries are never written.
- With ROM_LOAD_CHECKSUM_EN: write 0xFFFF, 0x0002 with SWAP=0 -> checksum=0x0001.
